// File: rtl/pc_sequencer.sv
// pc_sequencer: WIDTH-bit program counter with stall, fixed command
// priority and a circular return-address stack for nested call/ret.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   stall             freeze every register for this edge
//   increment         pc <- pc+1
//   branch            pc <- pc + sext(imm)
//   jump              pc <- target
//   call              push pc+1, pc <- target
//   ret               pop stack into pc
//   imm, target       branch displacement / absolute target
//   pc                current program counter
//   link              pc+1 captured at the last accepted command
//   redirect          pc was loaded non-sequentially on the last edge
//   ras_count         valid stack entries
//   ras_overflow      sticky: push landed on a full stack
//   ras_underflow     sticky: ret issued on an empty stack

module pc_sequencer #(
   parameter int               WIDTH        = 16,
   parameter int               IMM_WIDTH    = 16,
   parameter int               RAS_DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall,
   input  logic                             increment,
   input  logic                             branch,
   input  logic                             jump,
   input  logic                             call,
   input  logic                             ret,
   input  logic [IMM_WIDTH-1:0]             imm,
   input  logic [WIDTH-1:0]                 target,
   output logic [WIDTH-1:0]                 pc,
   output logic [WIDTH-1:0]                 link,
   output logic                             redirect,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
   output logic                             ras_overflow,
   output logic                             ras_underflow
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = $clog2(RAS_DEPTH);

   localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

   typedef enum logic [2:0] {
      CMD_HOLD,
      CMD_STALL,
      CMD_CALL,
      CMD_RET,
      CMD_BRANCH,
      CMD_JUMP,
      CMD_INC
   } cmd_e;

   cmd_e cmd;

   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PW-1:0]    top;

   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] imm_ext;
   logic [PW-1:0]    ptr_up;
   logic [PW-1:0]    ptr_dn;

   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] link_d;
   logic             redirect_d;
   logic [CW-1:0]    count_d;
   logic [PW-1:0]    top_d;
   logic             ovf_d;
   logic             unf_d;
   logic             push;

   assign pc_inc  = pc + WIDTH'(1);
   assign imm_ext = WIDTH'(signed'(imm));

   // Explicit wrap so non-power-of-two depths stay in range.
   assign ptr_up = (top == LAST) ? '0 : top + PW'(1);
   assign ptr_dn = (top == '0) ? LAST : top - PW'(1);

   // Resolve the strobes into the single winning command.
   always_comb begin
      cmd = CMD_HOLD;
      if (stall)          cmd = CMD_STALL;
      else if (call)      cmd = CMD_CALL;
      else if (ret)       cmd = CMD_RET;
      else if (branch)    cmd = CMD_BRANCH;
      else if (jump)      cmd = CMD_JUMP;
      else if (increment) cmd = CMD_INC;
   end

   always_comb begin
      pc_d       = pc;
      link_d     = link;
      redirect_d = 1'b0;
      count_d    = ras_count;
      top_d      = top;
      ovf_d      = ras_overflow;
      unf_d      = ras_underflow;
      push       = 1'b0;
      unique case (cmd)
         CMD_HOLD,
         CMD_STALL: begin
         end
         CMD_CALL: begin
            // On a full stack the slot above top is the oldest
            // entry, so advancing top overwrites it.
            push       = 1'b1;
            top_d      = ptr_up;
            pc_d       = target;
            link_d     = pc_inc;
            redirect_d = 1'b1;
            if (ras_count == FULL) begin
               ovf_d = 1'b1;
            end else begin
               count_d = ras_count + CW'(1);
            end
         end
         CMD_RET: begin
            link_d = pc_inc;
            if (ras_count != '0) begin
               pc_d       = stack[top];
               top_d      = ptr_dn;
               count_d    = ras_count - CW'(1);
               redirect_d = 1'b1;
            end else begin
               unf_d = 1'b1;
            end
         end
         CMD_BRANCH: begin
            pc_d       = pc + imm_ext;
            link_d     = pc_inc;
            redirect_d = 1'b1;
         end
         CMD_JUMP: begin
            pc_d       = target;
            link_d     = pc_inc;
            redirect_d = 1'b1;
         end
         CMD_INC: begin
            pc_d   = pc_inc;
            link_d = pc_inc;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_VECTOR;
         link          <= '0;
         redirect      <= 1'b0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
         top           <= '0;
      end else begin
         pc            <= pc_d;
         link          <= link_d;
         redirect      <= redirect_d;
         ras_count     <= count_d;
         ras_overflow  <= ovf_d;
         ras_underflow <= unf_d;
         top           <= top_d;
      end
   end

   // Stack storage needs no reset; validity is tracked by ras_count.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         stack[top_d] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table for the documented scenarios
// followed by randomized commands checked against a queue-based model.

module tb_pc_sequencer;

   localparam int W = 16;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stall = 1'b0;
   logic          increment = 1'b0;
   logic          branch = 1'b0;
   logic          jump = 1'b0;
   logic          call = 1'b0;
   logic          ret = 1'b0;
   logic [W-1:0]  imm = '0;
   logic [W-1:0]  target = '0;
   logic [W-1:0]  pc;
   logic [W-1:0]  link;
   logic          redirect;
   logic [2:0]    ras_count;
   logic          ras_overflow;
   logic          ras_underflow;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(
      .WIDTH(W),
      .IMM_WIDTH(W),
      .RAS_DEPTH(D),
      .RESET_VECTOR('0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .increment(increment),
      .branch(branch),
      .jump(jump),
      .call(call),
      .ret(ret),
      .imm(imm),
      .target(target),
      .pc(pc),
      .link(link),
      .redirect(redirect),
      .ras_count(ras_count),
      .ras_overflow(ras_overflow),
      .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         r, s, c, rt, b, j, i;
      logic [W-1:0] imm, tgt;
      logic [W-1:0] e_pc, e_link;
      logic         e_rd;
      logic [2:0]   e_cnt;
      logic         e_ovf, e_unf;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, s, c, rt, b, j, i,
                      input logic [W-1:0] im, tg, epc, elink,
                      input logic erd, input logic [2:0] ecnt,
                      input logic eovf, eunf);
      vec_t v;
      v.r = r; v.s = s; v.c = c; v.rt = rt;
      v.b = b; v.j = j; v.i = i;
      v.imm = im; v.tgt = tg;
      v.e_pc = epc; v.e_link = elink; v.e_rd = erd;
      v.e_cnt = ecnt; v.e_ovf = eovf; v.e_unf = eunf;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h",
                  name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, s, c, rt, b, j, i,
                        input logic [W-1:0] im, tg);
      @(negedge clk);
      rst = r; stall = s; call = c; ret = rt;
      branch = b; jump = j; increment = i;
      imm = im; target = tg;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input int idx, input logic [W-1:0] epc,
                            elink, input logic erd,
                            input logic [2:0] ecnt,
                            input logic eovf, eunf);
      chk("pc", idx, 32'(pc), 32'(epc));
      chk("link", idx, 32'(link), 32'(elink));
      chk("redirect", idx, 32'(redirect), 32'(erd));
      chk("ras_count", idx, 32'(ras_count), 32'(ecnt));
      chk("ras_overflow", idx, 32'(ras_overflow), 32'(eovf));
      chk("ras_underflow", idx, 32'(ras_underflow), 32'(eunf));
   endtask

   // Behavioural reference: the return stack is a queue of addresses
   // whose front is the oldest entry.
   logic [W-1:0] m_pc, m_link;
   logic         m_rd, m_ovf, m_unf;
   logic [W-1:0] m_ras[$];

   task automatic model_step(input logic r, s, c, rt, b, j, i,
                             input logic [W-1:0] im, tg);
      logic [W-1:0] nxt;
      nxt = m_pc + 16'd1;
      if (r) begin
         m_pc = '0; m_link = '0; m_rd = 0;
         m_ovf = 0; m_unf = 0;
         m_ras.delete();
      end else if (s) begin
         m_rd = 0;
      end else if (c) begin
         m_ras.push_back(nxt);
         if (m_ras.size() > D) begin
            void'(m_ras.pop_front());
            m_ovf = 1;
         end
         m_link = nxt; m_pc = tg; m_rd = 1;
      end else if (rt) begin
         m_link = nxt;
         if (m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
            m_rd = 1;
         end else begin
            m_unf = 1;
            m_rd = 0;
         end
      end else if (b) begin
         m_link = nxt; m_pc = m_pc + im; m_rd = 1;
      end else if (j) begin
         m_link = nxt; m_pc = tg; m_rd = 1;
      end else if (i) begin
         m_link = nxt; m_pc = nxt; m_rd = 0;
      end else begin
         m_rd = 0;
      end
   endtask

   initial begin
      // r s c rt b j i  imm      tgt      pc       link     rd cnt ov un
      add(1,0,0,0,0,0,0, 16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 0, 0);
      add(0,0,0,0,0,0,1, 16'h0,   16'h0,   16'h1,   16'h1,   0, 0, 0, 0);
      add(0,0,0,0,0,0,1, 16'h0,   16'h0,   16'h2,   16'h2,   0, 0, 0, 0);
      add(0,0,0,0,0,0,1, 16'h0,   16'h0,   16'h3,   16'h3,   0, 0, 0, 0);
      add(0,0,0,0,0,1,0, 16'h0,   16'hFFFF,16'hFFFF,16'h4,   1, 0, 0, 0);
      add(0,0,0,0,0,0,1, 16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 0, 0);
      add(0,0,0,0,1,0,0, 16'hFFFE,16'h0,   16'hFFFE,16'h1,   1, 0, 0, 0);
      add(0,0,0,0,0,0,0, 16'h0,   16'h0,   16'hFFFE,16'h1,   0, 0, 0, 0);
      add(0,0,0,0,0,1,0, 16'h0,   16'h10,  16'h10,  16'hFFFF,1, 0, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h100, 16'h100, 16'h11,  1, 1, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h200, 16'h200, 16'h101, 1, 2, 0, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h101, 16'h201, 1, 1, 0, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h11,  16'h102, 1, 0, 0, 0);
      add(0,0,0,0,0,1,0, 16'h0,   16'h1,   16'h1,   16'h12,  1, 0, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h2,   16'h2,   16'h2,   1, 1, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h3,   16'h3,   16'h3,   1, 2, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h4,   16'h4,   16'h4,   1, 3, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h5,   16'h5,   16'h5,   1, 4, 0, 0);
      add(0,0,1,0,0,0,0, 16'h0,   16'h6,   16'h6,   16'h6,   1, 4, 1, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h6,   16'h7,   1, 3, 1, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h5,   16'h7,   1, 2, 1, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h4,   16'h6,   1, 1, 1, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h3,   16'h5,   1, 0, 1, 0);
      add(0,0,0,1,0,0,0, 16'h0,   16'h0,   16'h3,   16'h4,   0, 0, 1, 1);
      add(0,1,1,0,0,0,0, 16'h0,   16'h300, 16'h3,   16'h4,   0, 0, 1, 1);
      add(0,0,1,0,1,0,1, 16'h5,   16'h40,  16'h40,  16'h4,   1, 1, 1, 1);
      add(0,0,1,0,0,0,0, 16'h0,   16'h50,  16'h50,  16'h41,  1, 2, 1, 1);
      add(1,1,0,0,0,0,0, 16'h0,   16'h0,   16'h0,   16'h0,   0, 0, 0, 0);

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].s, vecs[k].c, vecs[k].rt,
               vecs[k].b, vecs[k].j, vecs[k].i,
               vecs[k].imm, vecs[k].tgt);
         check_out(k, vecs[k].e_pc, vecs[k].e_link, vecs[k].e_rd,
                   vecs[k].e_cnt, vecs[k].e_ovf, vecs[k].e_unf);
      end

      // Stack must be empty after the reset above.
      drive(0,0,0,1,0,0,0, 16'h0, 16'h0);
      check_out(100, 16'h0, 16'h1, 0, 0, 0, 1);
      // Call then ret on the very next edge.
      drive(0,0,1,0,0,0,0, 16'h0, 16'h77);
      check_out(101, 16'h77, 16'h1, 1, 1, 0, 1);
      drive(0,0,0,1,0,0,0, 16'h0, 16'h0);
      check_out(102, 16'h1, 16'h78, 1, 0, 0, 1);

      // Randomized phase.
      m_pc = 'x;
      model_step(1,0,0,0,0,0,0, '0, '0);
      drive(1,0,0,0,0,0,0, '0, '0);
      check_out(1000, m_pc, m_link, m_rd,
                3'(m_ras.size()), m_ovf, m_unf);
      for (int n = 0; n < 1500; n++) begin
         logic r, s, c, rt, b, j, i;
         logic [W-1:0] im, tg;
         r  = ($urandom_range(0, 99) == 0);
         s  = ($urandom_range(0, 7) == 0);
         c  = ($urandom_range(0, 3) == 0);
         rt = ($urandom_range(0, 2) == 0);
         b  = ($urandom_range(0, 3) == 0);
         j  = ($urandom_range(0, 3) == 0);
         i  = ($urandom_range(0, 1) == 0);
         im = 16'($urandom);
         tg = 16'($urandom);
         model_step(r, s, c, rt, b, j, i, im, tg);
         drive(r, s, c, rt, b, j, i, im, tg);
         check_out(1001 + n, m_pc, m_link, m_rd,
                   3'(m_ras.size()), m_ovf, m_unf);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
